hdlc_tx_buffer_p: RTL
=====================

Name: hdlc_tx_buffer_p

Overview:
Parametrised HDLC transmit frame buffer. It is the next generation of the fixed 128x8 Tx buffer and sits between the register interface (write/enable/abort) and the Tx controller (read/avail). Width and depth are generic. The block adds overflow reporting, an explicit frame-latch state machine and abort pulse reporting.

Parameters:
DATA_W, 8, width of one buffered byte/word.
DEPTH, 128, number of buffer entries (>=2).
SIZE_W, $clog2(DEPTH+1), width of frame-size and pointer counters.

Ports:
Clk  in  1  system clock; all logic on rising edge.
Rst  in  1  asynchronous, active-high reset.
Tx_WrBuff  in  1  write Tx_DataInBuff into buffer (1-cycle strobe).
Tx_DataInBuff  in  DATA_W  data from register write.
Tx_Enable  in  1  latch frame and start transmission (strobe).
Tx_AbortFrame  in  1  abort current frame (strobe).
Tx_RdBuff  in  1  Tx controller consumes current Tx_DataOutBuff (strobe).
Tx_DataOutBuff  out  DATA_W  next word to transmit (registered).
Tx_DataAvail  out  1  Tx_DataOutBuff valid, more words pending.
Tx_Done  out  1  buffer in LOAD state, writable.
Tx_Full  out  1  DEPTH words stored.
Tx_FrameSize  out  SIZE_W  number of words in buffer/frame.
Tx_Overflow  out  1  sticky: write attempted while full.
Tx_AbortedTrans  out  1  1-cycle pulse: abort hit while in SEND.

Behaviour:
- Reset (async, any time incl. mid-frame): state=LOAD, wr_ptr=rd_ptr=0, Tx_DataOutBuff=0, Tx_DataAvail=0, Tx_Done=1, Tx_Full=0, Tx_FrameSize=0, Tx_Overflow=0, Tx_AbortedTrans=0. Memory contents are not reset.
- States: LOAD, SEND.
- LOAD:
  - Tx_WrBuff with wr_ptr<DEPTH: mem[wr_ptr]<=data; wr_ptr++.
  - Tx_FrameSize=wr_ptr. Tx_Full=(wr_ptr==DEPTH).
  - Write while full: data dropped, Tx_Overflow<=1.
  - Tx_RdBuff ignored.
- Tx_Enable in LOAD with wr_ptr>0 (or a same-cycle write making it >0):
  - Go to SEND. A same-cycle write is included in the frame.
  - Tx_Done<=0. rd_ptr<=0. Tx_DataOutBuff<=mem[0] (available the cycle after entry). Tx_DataAvail<=1.
  - Tx_Enable with an empty buffer is ignored. Tx_Enable in SEND is ignored.
- SEND:
  - Tx_FrameSize holds the latched count.
  - Tx_RdBuff: rd_ptr++. If rd_ptr+1<FrameSize, Tx_DataOutBuff<=mem[rd_ptr+1] (read latency 1 cycle).
  - On reading the last word: Tx_DataAvail<=0, state<=LOAD, wr_ptr<=0, Tx_Done<=1, Tx_Full<=0, Tx_FrameSize<=0.
  - Tx_WrBuff in SEND is ignored; no overflow is flagged.
- Tx_RdBuff while Tx_DataAvail=0: ignored.
- Tx_AbortFrame:
  - Highest priority over Enable/Wr/Rd in the same cycle.
  - Clears pointers and Tx_FrameSize; Tx_DataAvail<=0, Tx_Done<=1, state<=LOAD.
  - Tx_AbortedTrans pulses 1 cycle only if the state was SEND.
  - Abort in LOAD silently empties the buffer.
- Tx_Overflow clears on the next accepted Tx_Enable or on Tx_AbortFrame.
- Counter widths: pointers saturate at DEPTH, no wrap-around. Tx_FrameSize range is 0..DEPTH.
- Outputs are registered except Tx_Full and Tx_FrameSize, which are decoded from registered state.

Optional Feature:
HDLC_TX_BUF_STATS_EN
- Defined: adds outputs Tx_FramesSent[15:0] and Tx_FramesAborted[15:0].
  - Tx_FramesSent increments when a frame's last word is read.
  - Tx_FramesAborted increments on each Tx_AbortedTrans pulse.
  - Both saturate at 16'hFFFF and reset to 0 on Rst.
- Undefined: these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: Rst asserted mid-SEND with 5 words loaded -> same cycle Tx_Done=1, Tx_DataAvail=0, Tx_FrameSize=0; a subsequent Tx_Enable is ignored (buffer empty).
- Normal frame, DEPTH=128: write 0x7E,0x01,0xAA, then Tx_Enable -> Tx_FrameSize=3, Tx_DataOutBuff=0x7E. Three Tx_RdBuff strobes yield 0x01, 0xAA; Tx_DataAvail falls after the 3rd read; Tx_Done=1.
- Full/overflow, DEPTH=4: 5 writes (0x10..0x14) -> Tx_Full=1 after the 4th, Tx_Overflow=1 after the 5th. Frame sends 0x10..0x13 only; Tx_Overflow clears on Tx_Enable.
- Abort mid-send: 6 words, enable, 2 reads, then Tx_AbortFrame -> Tx_AbortedTrans high exactly 1 cycle, Tx_DataAvail=0, Tx_FrameSize=0. Abort in LOAD gives no pulse.
- Simultaneous events: Tx_WrBuff(0x55)+Tx_Enable same cycle with 1 word stored -> Tx_FrameSize=2, last word 0x55. Tx_Enable+Tx_AbortFrame same cycle -> stays LOAD, buffer empty.
- With HDLC_TX_BUF_STATS_EN and DATA_W=16: send 2 frames, abort 1 in SEND -> Tx_FramesSent=2, Tx_FramesAborted=1, and the 16-bit data path is correct.

Source files
------------

// File: rtl/hdlc_tx_buffer_p_if.sv
// hdlc_tx_buffer_p_if: signal bundle between register side, Tx controller and hdlc_tx_buffer_p
// slave (buffer) inputs : Tx_WrBuff, Tx_DataInBuff, Tx_Enable, Tx_AbortFrame, Tx_RdBuff
// slave (buffer) outputs: Tx_DataOutBuff, Tx_DataAvail, Tx_Done, Tx_Full, Tx_FrameSize,
//                         Tx_Overflow, Tx_AbortedTrans
// HDLC_TX_BUF_STATS_EN adds slave outputs Tx_FramesSent, Tx_FramesAborted
interface hdlc_tx_buffer_p_if #(
  parameter int DATA_W = 8,
  parameter int SIZE_W = 8
);
  logic              Tx_WrBuff;
  logic [DATA_W-1:0] Tx_DataInBuff;
  logic              Tx_Enable;
  logic              Tx_AbortFrame;
  logic              Tx_RdBuff;
  logic [DATA_W-1:0] Tx_DataOutBuff;
  logic              Tx_DataAvail;
  logic              Tx_Done;
  logic              Tx_Full;
  logic [SIZE_W-1:0] Tx_FrameSize;
  logic              Tx_Overflow;
  logic              Tx_AbortedTrans;
`ifdef HDLC_TX_BUF_STATS_EN
  logic [15:0]       Tx_FramesSent;
  logic [15:0]       Tx_FramesAborted;
  modport master (
    output Tx_WrBuff, Tx_DataInBuff, Tx_Enable, Tx_AbortFrame, Tx_RdBuff,
    input  Tx_DataOutBuff, Tx_DataAvail, Tx_Done, Tx_Full, Tx_FrameSize,
           Tx_Overflow, Tx_AbortedTrans, Tx_FramesSent, Tx_FramesAborted
  );
  modport slave (
    input  Tx_WrBuff, Tx_DataInBuff, Tx_Enable, Tx_AbortFrame, Tx_RdBuff,
    output Tx_DataOutBuff, Tx_DataAvail, Tx_Done, Tx_Full, Tx_FrameSize,
           Tx_Overflow, Tx_AbortedTrans, Tx_FramesSent, Tx_FramesAborted
  );
`else
  modport master (
    output Tx_WrBuff, Tx_DataInBuff, Tx_Enable, Tx_AbortFrame, Tx_RdBuff,
    input  Tx_DataOutBuff, Tx_DataAvail, Tx_Done, Tx_Full, Tx_FrameSize,
           Tx_Overflow, Tx_AbortedTrans
  );
  modport slave (
    input  Tx_WrBuff, Tx_DataInBuff, Tx_Enable, Tx_AbortFrame, Tx_RdBuff,
    output Tx_DataOutBuff, Tx_DataAvail, Tx_Done, Tx_Full, Tx_FrameSize,
           Tx_Overflow, Tx_AbortedTrans
  );
`endif
endinterface

// File: rtl/hdlc_tx_buffer_p.sv
// hdlc_tx_buffer_p: parametrised HDLC transmit frame buffer (LOAD/SEND frame latch)
// Clk    : system clock, rising edge
// Rst    : asynchronous active-high reset
// bus_io : slave side of hdlc_tx_buffer_p_if (write/enable/abort in, read/avail/status out)
// HDLC_TX_BUF_STATS_EN adds saturating Tx_FramesSent / Tx_FramesAborted counters
module hdlc_tx_buffer_p #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 128,
  parameter int SIZE_W = $clog2(DEPTH + 1)
) (
  input logic               Clk,
  input logic               Rst,
  hdlc_tx_buffer_p_if.slave bus_io
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [SIZE_W-1:0] FULL_C = SIZE_W'(DEPTH);
  typedef enum logic {LOAD, SEND} state_t;
  state_t state_q, state_d;
  logic [SIZE_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic avail_q, avail_d, done_q, done_d, ovf_q, ovf_d, abt_q, abt_d;
  logic abort, full, wr_ok, en_ok, rd_ok, last;
  logic [DATA_W-1:0] mem [DEPTH];
  assign abort  = bus_io.Tx_AbortFrame;
  assign full   = wr_ptr_q == FULL_C;
  assign wr_ok  = state_q == LOAD && bus_io.Tx_WrBuff && !full;
  assign en_ok  = state_q == LOAD && bus_io.Tx_Enable && (wr_ptr_q != '0 || wr_ok);
  assign rd_ok  = state_q == SEND && bus_io.Tx_RdBuff && avail_q;
  assign rd_nxt = rd_ptr_q + 1'b1;
  // in SEND wr_ptr holds the latched frame length
  assign last   = rd_nxt >= wr_ptr_q;
  always_ff @(posedge Clk)
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= bus_io.Tx_DataInBuff;
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    avail_d  = avail_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    abt_d    = 1'b0;
    if (abort) begin
      state_d  = LOAD;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      avail_d  = 1'b0;
      done_d   = 1'b1;
      ovf_d    = 1'b0;
      abt_d    = state_q == SEND;
    end else if (state_q == LOAD) begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (bus_io.Tx_WrBuff && full) ovf_d = 1'b1;
      if (en_ok) begin
        state_d  = SEND;
        rd_ptr_d = '0;
        // an empty buffer with a same-cycle write takes the word straight from the input
        dout_d   = wr_ptr_q == '0 ? bus_io.Tx_DataInBuff : mem[0];
        avail_d  = 1'b1;
        done_d   = 1'b0;
        ovf_d    = 1'b0;
      end
    end else if (rd_ok) begin
      rd_ptr_d = rd_nxt;
      if (last) begin
        state_d  = LOAD;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        avail_d  = 1'b0;
        done_d   = 1'b1;
      end else dout_d = mem[rd_nxt[AW-1:0]];
    end
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      avail_q  <= 1'b0;
      done_q   <= 1'b1;
      ovf_q    <= 1'b0;
      abt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      avail_q  <= avail_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      abt_q    <= abt_d;
    end
  assign bus_io.Tx_DataOutBuff  = dout_q;
  assign bus_io.Tx_DataAvail    = avail_q;
  assign bus_io.Tx_Done         = done_q;
  assign bus_io.Tx_Full         = full;
  assign bus_io.Tx_FrameSize    = wr_ptr_q;
  assign bus_io.Tx_Overflow     = ovf_q;
  assign bus_io.Tx_AbortedTrans = abt_q;
`ifdef HDLC_TX_BUF_STATS_EN
  logic [15:0] sent_q, abrtd_q;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      sent_q  <= '0;
      abrtd_q <= '0;
    end else begin
      if (!abort && rd_ok && last && sent_q != '1) sent_q <= sent_q + 1'b1;
      if (abt_d && abrtd_q != '1) abrtd_q <= abrtd_q + 1'b1;
    end
  assign bus_io.Tx_FramesSent    = sent_q;
  assign bus_io.Tx_FramesAborted = abrtd_q;
`endif
endmodule
